// File: rtl/ahb3lite_pkg.sv
// rtl/ahb3lite_pkg.sv - shared AHB3-Lite types, slave FSM states and size helpers
package ahb3lite_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } HTRANS_state;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'd0,
    HBURST_INCR   = 3'd1,
    HBURST_WRAP4  = 3'd2,
    HBURST_INCR4  = 3'd3,
    HBURST_WRAP8  = 3'd4,
    HBURST_INCR8  = 3'd5,
    HBURST_WRAP16 = 3'd6,
    HBURST_INCR16 = 3'd7
  } HBURST_Type;

  typedef enum logic {
    HRESP_OKAY  = 1'b0,
    HRESP_ERROR = 1'b1
  } HRESP_state;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RD,
    ST_ERR1,
    ST_ERR2
  } slave_state_t;

  localparam logic [2:0] AHB_SIZE_BYTE  = 3'd0;
  localparam logic [2:0] AHB_SIZE_HALF  = 3'd1;
  localparam logic [2:0] AHB_SIZE_WORD  = 3'd2;
  localparam logic [2:0] AHB_SIZE_DWORD = 3'd3;

  function automatic logic is_aligned(input logic [7:0] addr, input logic [2:0] size);
    logic [7:0] mask;
    mask = (8'd1 << size) - 8'd1;
    return (addr & mask) == 8'd0;
  endfunction

endpackage

// File: rtl/ahb3lite_byte_lane_dec.sv
// rtl/ahb3lite_byte_lane_dec.sv - HSIZE and address LSBs to per-byte lane enables
module ahb3lite_byte_lane_dec #(
  parameter int DATA_W = 32
) (
  input  logic [2:0]                      size,
  input  logic [$clog2(DATA_W/8)-1:0]     lsb,
  output logic [DATA_W/8-1:0]             be
);

  localparam int NB = DATA_W / 8;

  always_comb begin
    be = '0;
    for (int i = 0; i < NB; i++) begin
      if (i >= int'(lsb) && i < int'(lsb) + (1 << size)) be[i] = 1'b1;
    end
  end

endmodule

// File: rtl/ahb3lite_param_slave.sv
// rtl/ahb3lite_param_slave.sv - AHB3-Lite slave to single-port synchronous memory
// with programmable wait states, two-cycle ERROR and a saturating error counter.
module ahb3lite_param_slave
  import ahb3lite_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int MEM_BYTES = 4096,
  parameter int WAIT_W    = 4
) (
  input  logic                          HCLK,
  input  logic                          HRESETn,
  input  logic                          HSEL,
  input  logic [ADDR_W-1:0]             HADDR,
  input  HTRANS_state                   HTRANS,
  input  logic                          HWRITE,
  input  logic [2:0]                    HSIZE,
  input  HBURST_Type                    HBURST,
  input  logic [DATA_W-1:0]             HWDATA,
  input  logic                          HREADY,
  output logic                          HREADYOUT,
  output HRESP_state                    HRESP,
  output logic [DATA_W-1:0]             HRDATA,
  input  logic [WAIT_W-1:0]             cfg_wait_n,
  output logic [$clog2(MEM_BYTES)-1:0]  mem_addr,
  output logic                          mem_re,
  output logic                          mem_we,
  output logic [DATA_W/8-1:0]           mem_be,
  output logic [DATA_W-1:0]             mem_wdata,
  input  logic [DATA_W-1:0]             mem_rdata,
  output logic [15:0]                   err_cnt
);

  localparam int AW = $clog2(MEM_BYTES);
  localparam int NB = DATA_W / 8;
  localparam int LL = $clog2(NB);

  slave_state_t      state, state_nx;
  logic [NB-1:0]     be_q, be_dec;
  logic              rd_q, wr_pend;
  logic [WAIT_W-1:0] cnt_q, tgt_q;
  logic              accept, addr_err, last_wait;
  logic              unused_hburst;

  assign unused_hburst = ^HBURST;

  // New transfers are only taken in cycles where this slave completes with OKAY.
  assign accept = HSEL && HREADY && (HTRANS == HTRANS_NONSEQ || HTRANS == HTRANS_SEQ)
               && (state == ST_IDLE || state == ST_RD);

  assign addr_err = (HADDR >= ADDR_W'(MEM_BYTES)) || (HSIZE > 3'(LL))
                 || !is_aligned(HADDR[7:0], HSIZE);

  assign last_wait = (cnt_q == tgt_q - WAIT_W'(1));

  ahb3lite_byte_lane_dec #(.DATA_W(DATA_W)) u_lane_dec (
    .size (HSIZE),
    .lsb  (HADDR[LL-1:0]),
    .be   (be_dec)
  );

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state    <= ST_IDLE;
      mem_addr <= '0;
      be_q     <= '0;
      rd_q     <= 1'b0;
      wr_pend  <= 1'b0;
      cnt_q    <= '0;
      tgt_q    <= '0;
      err_cnt  <= '0;
    end else begin
      state   <= state_nx;
      wr_pend <= 1'b0;
      if (accept && !addr_err) begin
        mem_addr <= {HADDR[AW-1:LL], {LL{1'b0}}};
        be_q     <= be_dec;
        rd_q     <= !HWRITE;
        cnt_q    <= '0;
        // Reads always wait at least one cycle to cover the memory's read latency.
        tgt_q    <= (!HWRITE && cfg_wait_n == '0) ? WAIT_W'(1) : cfg_wait_n;
        wr_pend  <= HWRITE && (cfg_wait_n == '0);
      end else if (state == ST_WAIT) begin
        cnt_q   <= cnt_q + WAIT_W'(1);
        wr_pend <= !rd_q && last_wait;
      end
      if (state == ST_ERR1 && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
    end
  end

  always_comb begin
    state_nx  = state;
    HREADYOUT = 1'b1;
    HRESP     = HRESP_OKAY;
    HRDATA    = '0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_wdata = '0;
    case (state)
      ST_IDLE, ST_RD: begin
        if (state == ST_RD) HRDATA = mem_rdata;
        // A pending write commits in the completion cycle, when HWDATA is on the bus.
        if (wr_pend) begin
          mem_we    = 1'b1;
          mem_be    = be_q;
          mem_wdata = HWDATA;
        end
        state_nx = ST_IDLE;
        if (accept) begin
          if (addr_err)                            state_nx = ST_ERR1;
          else if (!HWRITE || cfg_wait_n != '0)    state_nx = ST_WAIT;
        end
      end
      ST_WAIT: begin
        HREADYOUT = 1'b0;
        if (rd_q && cnt_q == '0) begin
          mem_re = 1'b1;
          mem_be = be_q;
        end
        if (last_wait) state_nx = rd_q ? ST_RD : ST_IDLE;
      end
      ST_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = HRESP_ERROR;
        state_nx  = ST_ERR2;
      end
      ST_ERR2: begin
        HRESP    = HRESP_ERROR;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ahb3lite_param_slave.sv
// tb/tb_ahb3lite_param_slave.sv - self-checking bench for ahb3lite_param_slave
module tb_ahb3lite_param_slave;
  import ahb3lite_pkg::*;

  logic        HCLK, HRESETn, HSEL, HWRITE, hreadyout;
  logic [31:0] HADDR, HWDATA, HRDATA, mem_wdata, mem_rdata;
  HTRANS_state HTRANS;
  HBURST_Type  HBURST;
  HRESP_state  HRESP;
  logic [2:0]  HSIZE;
  logic [3:0]  cfg_wait_n, mem_be;
  logic [11:0] mem_addr;
  logic        mem_re, mem_we, mem_clr;
  logic [15:0] err_cnt;

  ahb3lite_param_slave dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HWDATA(HWDATA), .HREADY(hreadyout),
    .HREADYOUT(hreadyout), .HRESP(HRESP), .HRDATA(HRDATA), .cfg_wait_n(cfg_wait_n),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .err_cnt(err_cnt)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  // Synchronous single-port memory attached to the slave.
  logic [31:0] sim_mem [1024];
  always @(posedge HCLK) begin
    if (mem_clr) begin
      for (int i = 0; i < 1024; i++) sim_mem[i] <= 32'd0;
    end else begin
      if (mem_we)
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) sim_mem[mem_addr[11:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      if (mem_re) mem_rdata <= sim_mem[mem_addr[11:2]];
    end
  end

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] data;
    int          cfg;
    bit          err;
    int          waits;
    logic [3:0]  be;
    logic [31:0] rdata;
  } vec_t;

  typedef struct {
    int          waits;
    bit          resp_err;
    int          n_we;
    int          n_re;
    logic [3:0]  be;
    logic [11:0] addr;
    logic [31:0] rdata;
    logic [31:0] wdata;
  } obs_t;

  int          checks, errors;
  logic [31:0] ref_mem [1024];
  int          ref_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h, required %0h", name, act, exp);
    end
  endtask

  // Reference: transfer outcome from the address/size rules, byte-wise memory image.
  task automatic model_xfer(input bit wr, input logic [31:0] addr, input logic [2:0] size,
                            input logic [31:0] data, input int cfg, output bit e,
                            output int w, output logic [3:0] be, output logic [31:0] rd);
    int nbytes, idx;
    e  = (addr >= 32'd4096) || (size > 3'd2) || ((addr % (32'd1 << size)) != 0);
    be = 4'd0;
    rd = 32'd0;
    w  = 1;
    if (e) begin
      if (ref_err != 65535) ref_err++;
      return;
    end
    nbytes = 1 << size;
    idx    = int'(addr / 4);
    be     = 4'(((1 << nbytes) - 1) << (addr % 4));
    if (wr) begin
      w = cfg;
      for (int b = 0; b < 4; b++)
        if (be[b]) ref_mem[idx][8*b +: 8] = data[8*b +: 8];
    end else begin
      w  = (cfg == 0) ? 1 : cfg;
      rd = ref_mem[idx];
    end
  endtask

  task automatic drive_xfer(input bit wr, input logic [31:0] addr, input logic [2:0] size,
                            input logic [31:0] data, input int cfg, output obs_t o);
    bit done;
    o = '{default: '0};
    @(posedge HCLK); #1;
    HSEL = 1'b1; HTRANS = HTRANS_NONSEQ; HBURST = HBURST_SINGLE;
    HADDR = addr; HWRITE = wr; HSIZE = size; cfg_wait_n = 4'(cfg);
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = HTRANS_IDLE; HWDATA = data; cfg_wait_n = 4'($urandom);
    done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge HCLK);
      if (mem_we) begin o.n_we++; o.be = mem_be; o.addr = mem_addr; o.wdata = mem_wdata; end
      if (mem_re) begin o.n_re++; o.be = mem_be; o.addr = mem_addr; end
      if (hreadyout) begin
        done = 1'b1;
        o.resp_err = (HRESP == HRESP_ERROR);
        o.rdata = HRDATA;
      end else o.waits++;
    end
    chk("xfer_completed", 32'(done), 32'd1);
  endtask

  task automatic compare(input string tag, input bit wr, input logic [31:0] addr,
                         input logic [31:0] data, input bit e, input int w,
                         input logic [3:0] be, input logic [31:0] rd, input obs_t o);
    chk({tag, ".waits"}, 32'(o.waits), 32'(w));
    chk({tag, ".resp"},  32'(o.resp_err), 32'(e));
    chk({tag, ".n_we"},  32'(o.n_we), 32'(!e && wr));
    chk({tag, ".n_re"},  32'(o.n_re), 32'(!e && !wr));
    if (!e) begin
      chk({tag, ".be"},   32'(o.be), 32'(be));
      chk({tag, ".addr"}, 32'(o.addr), addr & 32'hFFC);
    end
    if (!e && wr) chk({tag, ".wdata"}, o.wdata, data);
    chk({tag, ".hrdata"}, o.rdata, (!e && !wr) ? rd : 32'd0);
    chk({tag, ".err_cnt"}, 32'(err_cnt), 32'(ref_err));
  endtask

  task automatic run_xfer(input string tag, input bit wr, input logic [31:0] addr,
                          input logic [2:0] size, input logic [31:0] data, input int cfg);
    bit e; int w; logic [3:0] be; logic [31:0] rd; obs_t o;
    model_xfer(wr, addr, size, data, cfg, e, w, be, rd);
    drive_xfer(wr, addr, size, data, cfg, o);
    compare(tag, wr, addr, data, e, w, be, rd, o);
  endtask

  vec_t vecs [10];

  initial begin
    bit e; int w; logic [3:0] be; logic [31:0] rd; obs_t o;
    logic [31:0] d [4];
    checks = 0; errors = 0; ref_err = 0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = 32'd0;

    vecs[0] = '{1'b1, 32'h10,   3'd2, 32'hDEADBEEF, 0, 1'b0, 0, 4'hF, 32'h0};
    vecs[1] = '{1'b0, 32'h10,   3'd2, 32'h0,        0, 1'b0, 1, 4'hF, 32'hDEADBEEF};
    vecs[2] = '{1'b1, 32'h13,   3'd0, 32'hAA000000, 3, 1'b0, 3, 4'h8, 32'h0};
    vecs[3] = '{1'b0, 32'h10,   3'd2, 32'h0,        2, 1'b0, 2, 4'hF, 32'hAAADBEEF};
    vecs[4] = '{1'b0, 32'h2000, 3'd2, 32'h0,        0, 1'b1, 1, 4'h0, 32'h0};
    vecs[5] = '{1'b1, 32'h11,   3'd1, 32'h5555,     0, 1'b1, 1, 4'h0, 32'h0};
    vecs[6] = '{1'b1, 32'h22,   3'd1, 32'h12345678, 1, 1'b0, 1, 4'hC, 32'h0};
    vecs[7] = '{1'b0, 32'h20,   3'd2, 32'h0,        0, 1'b0, 1, 4'hF, 32'h12340000};
    vecs[8] = '{1'b0, 32'h0,    3'd3, 32'h0,        0, 1'b1, 1, 4'h0, 32'h0};
    vecs[9] = '{1'b0, 32'h21,   3'd0, 32'h0,        4, 1'b0, 4, 4'h2, 32'h12340000};

    HRESETn = 1'b0; mem_clr = 1'b1; HSEL = 1'b0; HADDR = '0; HTRANS = HTRANS_IDLE;
    HWRITE = 1'b0; HSIZE = 3'd0; HBURST = HBURST_SINGLE; HWDATA = '0; cfg_wait_n = '0;
    repeat (2) @(posedge HCLK);
    @(negedge HCLK);
    chk("rst.hreadyout", 32'(hreadyout), 32'd1);
    chk("rst.hresp",     32'(HRESP), 32'd0);
    chk("rst.hrdata",    HRDATA, 32'd0);
    chk("rst.mem_re",    32'(mem_re), 32'd0);
    chk("rst.mem_we",    32'(mem_we), 32'd0);
    chk("rst.mem_be",    32'(mem_be), 32'd0);
    chk("rst.mem_addr",  32'(mem_addr), 32'd0);
    chk("rst.mem_wdata", mem_wdata, 32'd0);
    chk("rst.err_cnt",   32'(err_cnt), 32'd0);
    @(posedge HCLK); #1;
    HRESETn = 1'b1; mem_clr = 1'b0;

    for (int i = 0; i < 10; i++) begin
      model_xfer(vecs[i].wr, vecs[i].addr, vecs[i].size, vecs[i].data, vecs[i].cfg, e, w, be, rd);
      drive_xfer(vecs[i].wr, vecs[i].addr, vecs[i].size, vecs[i].data, vecs[i].cfg, o);
      compare($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].data,
              vecs[i].err, vecs[i].waits, vecs[i].be, vecs[i].rdata, o);
    end

    // INCR4 burst with zero wait states: four back-to-back data phases.
    for (int i = 0; i < 4; i++) d[i] = $urandom;
    @(posedge HCLK); #1;
    HSEL = 1'b1; HTRANS = HTRANS_NONSEQ; HBURST = HBURST_INCR4; HADDR = 32'h0;
    HWRITE = 1'b1; HSIZE = 3'd2; cfg_wait_n = 4'd0;
    for (int i = 1; i <= 4; i++) begin
      @(posedge HCLK); #1;
      if (i < 4) begin HTRANS = HTRANS_SEQ; HADDR = 32'(4 * i); end
      else begin HSEL = 1'b0; HTRANS = HTRANS_IDLE; end
      HWDATA = d[i-1];
      @(negedge HCLK);
      chk($sformatf("burst%0d.hreadyout", i), 32'(hreadyout), 32'd1);
      chk($sformatf("burst%0d.mem_we", i),    32'(mem_we), 32'd1);
      chk($sformatf("burst%0d.mem_addr", i),  32'(mem_addr), 32'(4 * (i - 1)));
      chk($sformatf("burst%0d.mem_wdata", i), mem_wdata, d[i-1]);
      model_xfer(1'b1, 32'(4 * (i - 1)), 3'd2, d[i-1], 0, e, w, be, rd);
    end
    for (int i = 0; i < 4; i++) run_xfer($sformatf("burst_rd%0d", i), 1'b0, 32'(4 * i), 3'd2, 32'h0, i);

    // Reset asserted while a write is stalled in wait states.
    run_xfer("pre_rst_wr", 1'b1, 32'h40, 3'd2, 32'h11223344, 0);
    @(posedge HCLK); #1;
    HSEL = 1'b1; HTRANS = HTRANS_NONSEQ; HBURST = HBURST_SINGLE; HADDR = 32'h40;
    HWRITE = 1'b1; HSIZE = 3'd2; cfg_wait_n = 4'd5;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = HTRANS_IDLE; HWDATA = 32'hCAFEF00D;
    @(posedge HCLK); #1;
    chk("midrst.stalled", 32'(hreadyout), 32'd0);
    HRESETn = 1'b0;
    #1;
    chk("midrst.hreadyout", 32'(hreadyout), 32'd1);
    chk("midrst.mem_we",    32'(mem_we), 32'd0);
    repeat (2) @(posedge HCLK);
    #1 HRESETn = 1'b1;
    ref_err = 0;
    chk("midrst.err_cnt", 32'(err_cnt), 32'd0);
    run_xfer("post_rst_rd", 1'b0, 32'h40, 3'd2, 32'h0, 0);

    // Randomized transfers, including the three error classes.
    for (int n = 0; n < 60; n++) begin
      int r; bit wr; logic [2:0] sz; logic [31:0] a;
      r  = $urandom_range(0, 9);
      wr = 1'($urandom_range(0, 1));
      sz = 3'($urandom_range(0, 2));
      a  = 32'($urandom_range(0, 255)) & ~((32'd1 << sz) - 32'd1);
      if (r == 0) a = 32'h1000 + 32'($urandom_range(0, 255) * 4);
      if (r == 1) sz = 3'd3;
      if (r == 2) begin sz = 3'($urandom_range(1, 2)); a = (a & 32'hFC) | 32'd1; end
      run_xfer($sformatf("rnd%0d", n), wr, a, sz, $urandom, $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahb3lite_param_slave.md
Name: ahb3lite_param_slave

Overview:
Parametrised next-generation AHB3-Lite memory-mapped slave between the AHB interconnect and a synchronous single-port memory. Generalised in data and address width and in memory depth. Adds:
- true address/data-phase pipelining with HSEL and HREADY;
- HSIZE byte-lane strobes;
- programmable wait states;
- a two-cycle ERROR response;
- a saturating error counter.

Parameters:
DATA_W, 32, data bus width; 32 or 64
ADDR_W, 32, HADDR width
MEM_BYTES, 4096, decoded region size in bytes; power of two
WAIT_W, 4, width of the wait-state configuration input

Ports:
HCLK  input  1  clock
HRESETn  input  1  reset
HSEL  input  1  slave select
HADDR  input  ADDR_W  address
HTRANS  input  HTRANS_state  transfer type
HWRITE  input  1  1 = write
HSIZE  input  3  transfer size
HBURST  input  HBURST_Type  burst type; not used for decode
HWDATA  input  DATA_W  write data
HREADY  input  1  bus-wide ready
HREADYOUT  output  1  slave ready
HRESP  output  HRESP_state  response
HRDATA  output  DATA_W  read data
cfg_wait_n  input  WAIT_W  extra wait cycles per transfer
mem_addr  output  log2(MEM_BYTES)  byte address, lane-aligned
mem_re  output  1  memory read strobe
mem_we  output  1  memory write strobe
mem_be  output  DATA_W/8  byte enables
mem_wdata  output  DATA_W  write data
mem_rdata  input  DATA_W  read data, valid 1 cycle after mem_re
err_cnt  output  16  saturating count of ERROR responses

Behaviour:
- Clocking and reset: one clock, HCLK. Reset HRESETn is asynchronous, active-low.
- Reset values: HREADYOUT=1, HRESP=OKAY, HRDATA=0, mem_re=mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, err_cnt=0, state=ST_IDLE.
- Address-phase accept: HSEL & HREADY & HTRANS∈{NONSEQ,SEQ} at a rising edge. On accept, capture HADDR, HWRITE, HSIZE.
- IDLE/BUSY with HSEL, or HSEL=0: no transfer. Next data phase is zero-wait OKAY.
- Error decode at accept: error when any of the following holds:
  - HADDR ≥ MEM_BYTES (offset decode);
  - HSIZE > log2(DATA_W/8);
  - HADDR not aligned to 2^HSIZE.
  Errored transfers never touch memory.
- State machine states: ST_IDLE, ST_WAIT, ST_RD, ST_ERR1, ST_ERR2.
- ST_IDLE, on accept:
  - error → ST_ERR1;
  - read → ST_WAIT with mem_re pulse;
  - write with cfg_wait_n>0 → ST_WAIT;
  - write with cfg_wait_n=0 → zero-wait write.
- Zero-wait write: HREADYOUT stays 1. mem_we=1 in the data-phase cycle, mem_wdata=HWDATA.
- ST_WAIT: HREADYOUT=0 while the counter is below its target.
  - Write target = cfg_wait_n.
  - Read target = max(cfg_wait_n,1). mem_re is issued on entry; the extra cycle covers memory latency.
  - On reaching target, HREADYOUT=1. Write: mem_we pulses with HWDATA. Read: HRDATA=mem_rdata registered. Then return to ST_IDLE, or chain directly on a new accept in the same cycle.
- ST_RD: holds HRDATA stable when cfg_wait_n=0; 1 wait minimum for reads.
- ST_ERR1: HREADYOUT=0, HRESP=ERROR; err_cnt++ (saturates at 0xFFFF).
- ST_ERR2: HREADYOUT=1, HRESP=ERROR. A pipelined address accepted here is discarded per AHB (master cancels → IDLE).
- cfg_wait_n is sampled at accept; mid-transfer changes are ignored.
- mem_be: lanes [addr_lsb +: 2^HSIZE] set, all others 0.
- mem_addr: low log2(DATA_W/8) bits zeroed.
- HRDATA: returns the full word; 0 outside read completion cycles.
- Back-to-back transfers: a new accept in the completion cycle (HREADYOUT=1) is processed without an idle bubble.
- Reset mid-transfer: immediate return to reset values; no partial write committed afterwards.

Decomposition:
- ahb3lite_pkg gains: the slave_state_t enum (5 states above), an AHB_SIZE_* constants set, and an is_aligned(addr,size) function.
- HTRANS_state, HBURST_Type and HRESP_state are reused from ahb3lite_pkg.
- One sub-module: ahb3lite_byte_lane_dec (HSIZE, addr LSBs → mem_be), parametrised by DATA_W.

Test Plan:
1. cfg_wait_n=0, NONSEQ write 32-bit HADDR=0x10 HWDATA=0xDEADBEEF → HREADYOUT never low; mem_we=1, mem_be=4'hF, mem_addr=0x10 in data phase; then read 0x10 → one wait cycle, HRDATA=0xDEADBEEF, HRESP=OKAY.
2. cfg_wait_n=3, write HSIZE=byte HADDR=0x13 data 0xAA000000 → exactly 3 HREADYOUT=0 cycles; mem_be=4'h8.
3. Read HADDR=0x2000 (MEM_BYTES=4096) → ERR1 (HREADYOUT=0, ERROR), then ERR2 (HREADYOUT=1, ERROR); mem_re stays 0; err_cnt=1.
4. Halfword write HADDR=0x11 → misaligned → two-cycle ERROR, no mem_we; err_cnt increments.
5. 4-beat INCR4 SEQ writes 0x0,0x4,0x8,0xC with cfg_wait_n=0 → four consecutive mem_we cycles, no bubbles; readback matches.
6. Assert HRESETn low during ST_WAIT of a write → HREADYOUT=1, mem_we=0 immediately; memory word unchanged after release.
